// File: rtl/latch_rf_wr_sched_pkg.sv
// Shared types for the latch register-file write scheduler.
// LATCH_RF_PARITY_EN widens the latch data bus by one even-parity bit.
`timescale 1ns/1ps
package latch_rf_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, CLEAR} state_e;
    typedef enum logic {REQ_A, REQ_B} req_id_e;

`ifdef LATCH_RF_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    // LAT_D_W for a given payload width
    function automatic int lat_d_w(input int data_w);
        return data_w + PAR_W;
    endfunction

endpackage

// File: rtl/latch_rf_wr_sched_if.sv
// Requester, clear and latch-array signals of the write scheduler.
// lat_d width follows LATCH_RF_PARITY_EN through latch_rf_pkg.
`timescale 1ns/1ps
interface latch_rf_wr_sched_if #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    localparam int LD_W = latch_rf_pkg::lat_d_w(DATA_W);

    logic              a_valid, a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid, b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              clr_req, clr_ack;
    logic [LD_W-1:0]   lat_d;
    logic [DEPTH-1:0]  lat_en;
    logic              lat_rstb;
    logic              busy;
    logic              addr_err;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_req,
        input  a_ready, b_ready, clr_ack, lat_d, lat_en, lat_rstb, busy, addr_err
    );
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, clr_req,
        output a_ready, b_ready, clr_ack, lat_d, lat_en, lat_rstb, busy, addr_err
    );
endinterface

// File: rtl/latch_rf_wr_sched_arb.sv
// Two-way round-robin arbiter; the pointer moves past whichever side was granted.
`timescale 1ns/1ps
module latch_rf_rr_arb
    import latch_rf_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTB,
    input  logic [1:0] vld,
    input  logic       en,
    output logic [1:0] gnt
);
    req_id_e ptr, pick;

    always_comb begin
        pick = ptr;
        if (vld == 2'b01)      pick = REQ_A;
        else if (vld == 2'b10) pick = REQ_B;
        gnt = 2'b00;
        if (en && (|vld)) gnt = (pick == REQ_B) ? 2'b10 : 2'b01;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB)
            ptr <= REQ_A;
        else if (en && (|vld))
            ptr <= (pick == REQ_A) ? REQ_B : REQ_A;
    end
endmodule

// File: rtl/latch_rf_wr_sched.sv
// Write scheduler for an SR-latch register file: arbitrates A/B, sequences
// setup/open/hold around a one-hot enable and runs bulk clears. Option: LATCH_RF_PARITY_EN.
`timescale 1ns/1ps
module latch_rf_wr_sched
    import latch_rf_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 1,
    parameter int HOLD_CYC  = 1,
    parameter int CLR_CYC   = 2
) (
    input logic CLK,
    input logic RSTB,
    latch_rf_wr_sched_if.slave bus
);
    localparam int LD_W   = lat_d_w(DATA_W);
    localparam int MAX_SO = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int MAX_HC = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
    localparam int MAXC   = (MAX_SO > MAX_HC) ? MAX_SO : MAX_HC;
    localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_e            state, nxt;
    logic [CNT_W-1:0]  cnt;
    logic              arb_en, grant;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] cap_addr, g_addr;
    logic [DATA_W-1:0] g_data;
    logic [LD_W-1:0]   g_word;
    logic              oob;
    logic [DEPTH-1:0]  dec;

    latch_rf_rr_arb u_arb (
        .CLK  (CLK),
        .RSTB (RSTB),
        .vld  ({bus.b_valid, bus.a_valid}),
        .en   (arb_en),
        .gnt  (gnt)
    );

    // Ready is combinational from the grant; forced low while reset is held
    assign grant       = |gnt;
    assign bus.a_ready = RSTB & gnt[0];
    assign bus.b_ready = RSTB & gnt[1];
    assign g_addr      = gnt[1] ? bus.b_addr : bus.a_addr;
    assign g_data      = gnt[1] ? bus.b_data : bus.a_data;

`ifdef LATCH_RF_PARITY_EN
    assign g_word = {^g_data, g_data};
`else
    assign g_word = g_data;
`endif

    assign oob = 32'(cap_addr) >= DEPTH;

    always_comb begin
        dec = '0;
        for (int i = 0; i < DEPTH; i++)
            dec[i] = (cap_addr == ADDR_W'(i));
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        nxt    = state;
        arb_en = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_req) nxt = CLEAR;
                else begin
                    arb_en = 1'b1;
                    if (grant) nxt = SETUP;
                end
            end
            SETUP:   if (cnt == CNT_W'(SETUP_CYC - 1)) nxt = OPEN;
            OPEN:    if (cnt == CNT_W'(OPEN_CYC - 1))  nxt = HOLD;
            HOLD:    if (cnt == CNT_W'(HOLD_CYC - 1))  nxt = IDLE;
            CLEAR:   if (cnt == CNT_W'(CLR_CYC - 1))   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each lines up with its state cycle
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            cap_addr     <= '0;
            bus.lat_d    <= '0;
            bus.lat_en   <= '0;
            bus.lat_rstb <= 1'b1;
            bus.clr_ack  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.addr_err <= 1'b0;
        end else begin
            if (grant) begin
                cap_addr  <= g_addr;
                bus.lat_d <= g_word;
            end
            bus.lat_en   <= (nxt == OPEN && !oob) ? dec : '0;
            bus.addr_err <= (state == SETUP) && (nxt == OPEN) && oob;
            bus.lat_rstb <= (nxt != CLEAR);
            bus.clr_ack  <= (state == CLEAR) && (nxt == IDLE);
            bus.busy     <= (nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_latch_rf_wr_sched.sv
// Directed bench for latch_rf_wr_sched: per-write vector table plus clear and reset sequences.
`timescale 1ns/1ps
module tb_latch_rf_wr_sched;
    import latch_rf_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int LD_W   = lat_d_w(DATA_W);

    logic CLK = 1'b0;
    logic RSTB = 1'b0;
    always #5 CLK = ~CLK;

    latch_rf_wr_sched_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    latch_rf_wr_sched #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SETUP_CYC(1), .OPEN_CYC(1), .HOLD_CYC(1), .CLR_CYC(2)
    ) dut (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus.slave)
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [7:0]  ad;
        logic        bv;
        logic [4:0]  ba;
        logic [7:0]  bd;
        logic        ea;
        logic        eb;
        logic [15:0] een;
        logic [7:0]  ed;
        logic        eerr;
    } vec_t;

    vec_t tbl [9];
    int checks = 0;
    int errors = 0;

    function automatic logic [LD_W-1:0] exp_ld(input logic [7:0] d);
`ifdef LATCH_RF_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bus.a_valid = v.av; bus.a_addr = v.aa; bus.a_data = v.ad;
        bus.b_valid = v.bv; bus.b_addr = v.ba; bus.b_data = v.bd;
        @(negedge CLK);
        chk($sformatf("v%0d_idle_busy", idx), 32'(bus.busy), 0);
        chk($sformatf("v%0d_a_ready", idx), 32'(bus.a_ready), 32'(v.ea));
        chk($sformatf("v%0d_b_ready", idx), 32'(bus.b_ready), 32'(v.eb));
        @(posedge CLK); #1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(negedge CLK);
        chk($sformatf("v%0d_setup_en", idx), 32'(bus.lat_en), 0);
        chk($sformatf("v%0d_setup_d", idx), 32'(bus.lat_d), 32'(exp_ld(v.ed)));
        chk($sformatf("v%0d_setup_busy", idx), 32'(bus.busy), 1);
        @(negedge CLK);
        chk($sformatf("v%0d_open_en", idx), 32'(bus.lat_en), 32'(v.een));
        chk($sformatf("v%0d_open_err", idx), 32'(bus.addr_err), 32'(v.eerr));
        chk($sformatf("v%0d_open_d", idx), 32'(bus.lat_d), 32'(exp_ld(v.ed)));
        @(negedge CLK);
        chk($sformatf("v%0d_hold_en", idx), 32'(bus.lat_en), 0);
        chk($sformatf("v%0d_hold_err", idx), 32'(bus.addr_err), 0);
        chk($sformatf("v%0d_hold_d", idx), 32'(bus.lat_d), 32'(exp_ld(v.ed)));
        @(posedge CLK); #1;
    endtask

    initial begin
        int  lows;
        logic seen;

        //           av   aa     ad     bv   ba     bd     ea   eb   een       ed     err
        tbl[0] = '{1'b1, 5'd3,  8'h5A, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 16'h0008, 8'h5A, 1'b0};
        tbl[1] = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd9,  8'hC3, 1'b0, 1'b1, 16'h0200, 8'hC3, 1'b0};
        tbl[2] = '{1'b1, 5'd1,  8'h11, 1'b1, 5'd2,  8'h22, 1'b1, 1'b0, 16'h0002, 8'h11, 1'b0};
        tbl[3] = '{1'b1, 5'd4,  8'h44, 1'b1, 5'd5,  8'h55, 1'b0, 1'b1, 16'h0020, 8'h55, 1'b0};
        tbl[4] = '{1'b1, 5'd6,  8'h66, 1'b1, 5'd7,  8'h77, 1'b1, 1'b0, 16'h0040, 8'h66, 1'b0};
        tbl[5] = '{1'b1, 5'd8,  8'h88, 1'b1, 5'd15, 8'hF0, 1'b0, 1'b1, 16'h8000, 8'hF0, 1'b0};
        tbl[6] = '{1'b0, 5'd0,  8'h00, 1'b1, 5'd20, 8'hAB, 1'b0, 1'b1, 16'h0000, 8'hAB, 1'b1};
        tbl[7] = '{1'b1, 5'd0,  8'h07, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 16'h0001, 8'h07, 1'b0};
        tbl[8] = '{1'b1, 5'd16, 8'h03, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 16'h0000, 8'h03, 1'b1};

        bus.a_valid = 1'b1; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        bus.clr_req = 1'b0;

        #12;
        chk("rst_a_ready", 32'(bus.a_ready), 0);
        chk("rst_lat_en", 32'(bus.lat_en), 0);
        chk("rst_lat_d", 32'(bus.lat_d), 0);
        chk("rst_lat_rstb", 32'(bus.lat_rstb), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_clr_ack", 32'(bus.clr_ack), 0);
        chk("rst_addr_err", 32'(bus.addr_err), 0);
        bus.a_valid = 1'b0;
        @(negedge CLK); RSTB = 1'b1;
        @(posedge CLK); #1;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Clear takes priority over a pending A write, then A proceeds
        bus.clr_req = 1'b1;
        bus.a_valid = 1'b1; bus.a_addr = 5'd10; bus.a_data = 8'h5C;
        @(negedge CLK);
        chk("clr_a_ready_blocked", 32'(bus.a_ready), 0);
        chk("clr_idle_rstb", 32'(bus.lat_rstb), 1);
        lows = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            chk("clr_lat_en", 32'(bus.lat_en), 0);
            if (!bus.lat_rstb) lows++;
            if (bus.clr_ack) seen = 1'b1;
        end
        bus.clr_req = 1'b0;
        chk("clr_ack_seen", 32'(seen), 1);
        chk("clr_low_cycles", 32'(lows), 2);
        chk("clr_ack_rstb", 32'(bus.lat_rstb), 1);
        #1;
        chk("clr_then_a_ready", 32'(bus.a_ready), 1);
        @(posedge CLK); #1;
        bus.a_valid = 1'b0;
        @(negedge CLK);
        chk("clr_ack_pulse_end", 32'(bus.clr_ack), 0);
        @(negedge CLK);
        chk("clr_write_en", 32'(bus.lat_en), 32'h0400);
        @(negedge CLK);
        @(posedge CLK); #1;

        // Reset during OPEN kills the enable and re-arms the pointer to A
        bus.a_valid = 1'b1; bus.a_addr = 5'd12; bus.a_data = 8'h99;
        @(posedge CLK); #1;
        bus.a_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("mid_open_en", 32'(bus.lat_en), 32'h1000);
        #2 RSTB = 1'b0;
        #1;
        chk("mid_rst_en", 32'(bus.lat_en), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_lat_d", 32'(bus.lat_d), 0);
        @(negedge CLK);
        RSTB = 1'b1;
        bus.a_valid = 1'b1; bus.a_addr = 5'd2;  bus.a_data = 8'h3C;
        bus.b_valid = 1'b1; bus.b_addr = 5'd13; bus.b_data = 8'hE1;
        #1;
        chk("post_rst_a_ready", 32'(bus.a_ready), 1);
        chk("post_rst_b_ready", 32'(bus.b_ready), 0);
        @(posedge CLK); #1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("post_rst_en", 32'(bus.lat_en), 32'h0004);
        chk("post_rst_d", 32'(bus.lat_d), 32'(exp_ld(8'h3C)));
        @(negedge CLK);
        @(negedge CLK);
        chk("post_rst_idle", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/latch_rf_wr_sched.md
Name: latch_rf_wr_sched

Overview:
- Write scheduler for a latch-based register file built from set/reset latch cells with inverted output.
- Arbitrates two write requesters round-robin and stages data ahead of the latch enable.
- Generates one-hot latch-enable pulses, honouring cell setup/hold with programmable margins.
- Sequences a bulk clear through the shared active-low latch reset.

Parameters:
- DEPTH, 16, number of latch entries
- ADDR_W, 4, address width; DEPTH <= 2**ADDR_W
- DATA_W, 8, payload width
- SETUP_CYC, 1, cycles data is stable before enable opens (>=1)
- OPEN_CYC, 1, cycles enable is held high (>=1)
- HOLD_CYC, 1, cycles data is held after enable closes (>=1)
- CLR_CYC, 2, cycles lat_rstb is held low during a clear (>=1)

Ports:
- CLK  in  1  clock
- RSTB  in  1  reset, asynchronous, active-low
- a_valid  in  1  requester A write request
- a_ready  out  1  A accepted this cycle
- a_addr  in  ADDR_W  A entry index
- a_data  in  DATA_W  A payload
- b_valid  in  1  requester B write request
- b_ready  out  1  B accepted this cycle
- b_addr  in  ADDR_W  B entry index
- b_data  in  DATA_W  B payload
- clr_req  in  1  bulk clear request (level)
- clr_ack  out  1  one-cycle pulse on clear completion
- lat_d  out  DATA_W(+1)  data bus to all latch D pins
- lat_en  out  DEPTH  one-hot latch enables
- lat_rstb  out  1  active-low reset to all entries
- busy  out  1  state != IDLE
- addr_err  out  1  one-cycle pulse: out-of-range address accepted

Behaviour:
- Reset (async, RSTB=0): state=IDLE, a_ready=b_ready=0, lat_en=0, lat_d=0, lat_rstb=1, clr_ack=0, busy=0, addr_err=0, rr pointer=A. A reset mid-sequence drops lat_en immediately; the write in flight is lost.
- States: IDLE, SETUP, OPEN, HOLD, CLEAR. All outputs are registered.
- IDLE:
  - clr_req=1 has priority over writes: go to CLEAR, no ready.
  - Else, if any valid: grant one requester and assert its ready combinationally that cycle. Transfer occurs on valid&ready.
  - Both valid: grant the rr-pointer side; pointer flips to the other side after each grant. Single valid: grant it; pointer flips to the other side.
  - On grant: capture addr/data, drive lat_d, go to SETUP.
- SETUP: SETUP_CYC cycles, lat_d stable, lat_en=0. Then OPEN.
- OPEN: OPEN_CYC cycles.
  - addr<DEPTH: lat_en[addr]=1.
  - addr>=DEPTH: lat_en=0 and addr_err pulses on the first OPEN cycle.
  - Then HOLD.
- HOLD: HOLD_CYC cycles, lat_en=0, lat_d unchanged. Then IDLE.
- Throughput: one write per SETUP_CYC+OPEN_CYC+HOLD_CYC+1 cycles. With all parameters =1, accept at edge T gives lat_en high during cycle T+2 only.
- CLEAR: lat_rstb=0 for CLR_CYC cycles, lat_en=0. Then lat_rstb=1, clr_ack pulses for 1 cycle, return to IDLE.
  - clr_req still high at that IDLE re-triggers CLEAR; the requester must drop clr_req on clr_ack.
- clr_req rising during SETUP/OPEN/HOLD does not abort the write; the clear is taken at the next IDLE, ahead of pending writes.
- lat_en is never multi-hot and never high while lat_rstb=0. lat_d never changes while any lat_en bit is high or in HOLD.
- Cycle counter width is clog2 of the max of the SETUP/OPEN/HOLD/CLR parameters; it is reset on every state entry.

Optional Feature:
- LATCH_RF_PARITY_EN
  - Defined: lat_d is DATA_W+1 bits; MSB = even parity (XOR) of data, computed at capture.
  - Undefined: lat_d is DATA_W bits, no parity logic.

Decomposition:
- Package latch_rf_pkg holds:
  - state enum (IDLE, SETUP, OPEN, HOLD, CLEAR)
  - requester-id enum (REQ_A, REQ_B)
  - LAT_D_W constant derived from the macro
- Sub-module latch_rf_rr_arb: 2-way round-robin arbiter (valids, enable, grant one-hot, pointer update on grant).

Test Plan:
- Reset then A writes addr=3 data=0x5A, defaults → a_ready 1 cycle; lat_d=0x5A from T+1; lat_en=0x0008 during T+2 only; busy low at T+4.
- A and B both valid from IDLE after reset → A granted first, B second. With both held valid, grants alternate A,B,A,B over 4 writes.
- clr_req and a_valid both high in IDLE, CLR_CYC=2 → lat_rstb low 2 cycles, clr_ack pulse, then A write proceeds; lat_en 0 throughout the clear.
- B writes addr=20 with DEPTH=16, ADDR_W=5 → b_ready handshake, addr_err pulse, lat_en stays 0, normal HOLD/IDLE timing.
- RSTB asserted during OPEN → lat_en=0 asynchronously, state IDLE; next write behaves as after reset (A granted first).
- With LATCH_RF_PARITY_EN, write data=0x07 → lat_d=0x107; data=0x03 → lat_d=0x003.
